// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Purpose  : Shared definitions for the JK flop-bank command sequencer:
//            op encoding, sequencer states, requester ids and the
//            expected-value helper used for read-back checking.
// Revision : 1.0 - initial release
// ============================================================================
package jk_pkg;

    // Op encoding: bit 0 drives J, bit 1 drives K.
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    // Sequencer states. Each one lasts exactly one cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    // Requester ids. These double as the last-grant encoding.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Value the addressed flop should hold after applying op to old.
    function automatic logic expected_bit(input logic [1:0] op, input logic old);
        logic res;
        case (op)
            OP_SET:  res = 1'b1;
            OP_CLR:  res = 1'b0;
            OP_TGL:  res = ~old;
            default: res = old;
        endcase
        return res;
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : jk_rr_arb2
// Purpose  : Two-way round-robin arbiter. On a tie the requester that was
//            not granted last wins. After reset, A wins the first tie.
// Revision : 1.0 - initial release
// ============================================================================
module jk_rr_arb2
    import jk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;

    assign grant[0] = req[0] & (~req[1] | (last_grant_q == SRC_B));
    assign grant[1] = req[1] & ~grant[0];

    // Remember the winner whenever the consumer takes the granted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= SRC_B;
        end else if (advance) begin
            last_grant_q <= grant[1] ? SRC_B : SRC_A;
        end
    end

endmodule : jk_rr_arb2
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_ctrl
// Purpose  : Command sequencer for an external bank of JK flops. It
//            arbitrates two requesters, drives a one-cycle J/K pulse on the
//            addressed bit, reads back Q and reports completion with a
//            mismatch flag.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_ctrl
    import jk_pkg::*;
#(
    parameter int N_BITS = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [1:0]        a_op,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [1:0]        b_op,
    output logic [N_BITS-1:0] j_out,
    output logic [N_BITS-1:0] k_out,
    input  logic [N_BITS-1:0] q_in,
    output logic              busy,
    output logic              done,
    output logic              done_src,
    output logic              done_q,
    output logic              err
);

    localparam logic [N_BITS-1:0] c_ONE = {{(N_BITS-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          op_q;
    logic                src_q;
    logic                old_q;
    logic [N_BITS-1:0]   j_q;
    logic [N_BITS-1:0]   k_q;
    logic                done_pulse_q;
    logic                done_src_q;
    logic                done_val_q;
    logic                err_q;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_idle;
    logic                w_accept;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [1:0]          w_sel_op;
    logic [N_BITS-1:0]   w_sel_mask;
    logic [N_BITS-1:0]   w_cur_mask;
    logic                w_cur_bit;
    logic                w_illegal;

    assign w_req = {b_valid, a_valid};

    jk_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req),
        .advance (w_accept),
        .grant   (w_grant)
    );

    // Ready is combinational but only offered in IDLE and never under reset.
    assign w_idle   = (state_q == ST_IDLE);
    assign a_ready  = w_idle & ~reset & w_grant[0];
    assign b_ready  = w_idle & ~reset & w_grant[1];
    assign w_accept = a_ready | b_ready;

    assign w_sel_idx = w_grant[1] ? b_idx : a_idx;
    assign w_sel_op  = w_grant[1] ? b_op  : a_op;

    // A one-hot shift past the top of the bank yields all-zero, so an
    // out-of-range index naturally drives nothing and reads back 0.
    assign w_sel_mask = c_ONE << w_sel_idx;
    assign w_cur_mask = c_ONE << idx_q;
    assign w_cur_bit  = |(q_in & w_cur_mask);
    assign w_illegal  = (32'(idx_q) >= 32'(N_BITS));

    // Sequencer: accept in IDLE, pulse J/K during DRIVE, check during SAMPLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            op_q         <= OP_HOLD;
            src_q        <= SRC_A;
            old_q        <= 1'b0;
            j_q          <= '0;
            k_q          <= '0;
            done_pulse_q <= 1'b0;
            done_src_q   <= SRC_A;
            done_val_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        idx_q   <= w_sel_idx;
                        op_q    <= w_sel_op;
                        src_q   <= w_grant[1] ? SRC_B : SRC_A;
                        j_q     <= w_sel_op[0] ? w_sel_mask : '0;
                        k_q     <= w_sel_op[1] ? w_sel_mask : '0;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    j_q     <= '0;
                    k_q     <= '0;
                    old_q   <= w_cur_bit;
                    state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    done_pulse_q <= 1'b1;
                    done_src_q   <= src_q;
                    done_val_q   <= w_cur_bit;
                    err_q        <= w_illegal |
                                    (w_cur_bit != expected_bit(op_q, old_q));
                    state_q      <= ST_IDLE;
                end
                default: begin
                    j_q     <= '0;
                    k_q     <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign j_out    = j_q;
    assign k_out    = k_q;
    assign busy     = ~w_idle;
    assign done     = done_pulse_q;
    assign done_src = done_src_q;
    assign done_q   = done_val_q;
    assign err      = err_q;

endmodule : jk_bank_ctrl
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_ctrl
// Purpose  : Directed testbench for jk_bank_ctrl with a behavioural JK bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_ctrl;

    localparam int N_BITS = 8;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [1:0]        a_op, b_op;
    logic [N_BITS-1:0] j_out, k_out, q_in;
    logic              busy, done, done_src, done_q, err;

    logic [N_BITS-1:0] bank_q;
    logic              bank_clr;
    logic              stuck5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jk_bank_ctrl #(.N_BITS(N_BITS), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_idx    (a_idx),
        .a_op     (a_op),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_idx    (b_idx),
        .b_op     (b_op),
        .j_out    (j_out),
        .k_out    (k_out),
        .q_in     (q_in),
        .busy     (busy),
        .done     (done),
        .done_src (done_src),
        .done_q   (done_q),
        .err      (err)
    );

    // Behavioural JK bank with an optional stuck-at-0 fault on bit 5.
    always_ff @(posedge clk) begin
        if (bank_clr) begin
            bank_q <= '0;
        end else begin
            for (int i = 0; i < N_BITS; i++) begin
                case ({k_out[i], j_out[i]})
                    2'b01:   bank_q[i] <= 1'b1;
                    2'b10:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end
    assign q_in = bank_q & ~(stuck5 ? 8'h20 : 8'h00);

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; bank_clr = 1'b1;
        cyc(); cyc();
        reset = 1'b0; bank_clr = 1'b0;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; a_idx = 4'd0; a_op = 2'b01;
        b_valid = 1'b1; b_idx = 4'd1; b_op = 2'b01;
        reset = 1'b1; bank_clr = 1'b1;
        cyc(); cyc();
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b exp=0", b_ready); end
        total++; if ({j_out, k_out} !== 16'h0) begin bad++; $display("FAIL reset_jk got=%h exp=0", {j_out, k_out}); end
        total++; if ({busy, done, done_src, done_q, err} !== 5'b0) begin bad++;
            $display("FAIL reset_status got=%b exp=00000", {busy, done, done_src, done_q, err}); end
        a_valid = 1'b0; b_valid = 1'b0;
        reset = 1'b0; bank_clr = 1'b0;
        cyc();
    endtask

    task automatic test_set();
        a_valid = 1'b1; a_idx = 4'd3; a_op = 2'b01;
        #1;
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++;
            $display("FAIL set_ready got=%b%b exp=10", a_ready, b_ready); end
        cyc(); a_valid = 1'b0; #1;
        total++; if (j_out !== 8'h08 || k_out !== 8'h00 || busy !== 1'b1) begin bad++;
            $display("FAIL set_drive got j=%h k=%h busy=%b exp j=08 k=00 busy=1", j_out, k_out, busy); end
        cyc(); #1;
        total++; if (j_out !== 8'h00 || k_out !== 8'h00 || done !== 1'b0) begin bad++;
            $display("FAIL set_sample got j=%h k=%h done=%b exp 00 00 0", j_out, k_out, done); end
        cyc(); #1;
        total++; if ({done, done_src, done_q, err, busy} !== 5'b10100) begin bad++;
            $display("FAIL set_done got=%b exp=10100", {done, done_src, done_q, err, busy}); end
        cyc(); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL set_done_width got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        a_valid = 1'b1; a_idx = 4'd3; a_op = 2'b11;
        cyc(); #1;
        total++; if (j_out !== 8'h08 || k_out !== 8'h08) begin bad++;
            $display("FAIL tgl1_drive got j=%h k=%h exp 08 08", j_out, k_out); end
        cyc(); cyc(); #1;
        total++; if ({done, done_q, err, a_ready} !== 4'b1001) begin bad++;
            $display("FAIL tgl1_done got=%b exp=1001", {done, done_q, err, a_ready}); end
        cyc(); a_valid = 1'b0; #1;
        total++; if (j_out !== 8'h08 || k_out !== 8'h08) begin bad++;
            $display("FAIL tgl2_drive got j=%h k=%h exp 08 08", j_out, k_out); end
        cyc(); cyc(); #1;
        total++; if ({done, done_q, err} !== 3'b110) begin bad++;
            $display("FAIL tgl2_done got=%b exp=110", {done, done_q, err}); end
        cyc();
    endtask

    task automatic test_arbitration();
        logic exp_src;
        do_reset();
        a_valid = 1'b1; a_idx = 4'd0; a_op = 2'b10;
        b_valid = 1'b1; b_idx = 4'd7; b_op = 2'b01;
        for (int n = 0; n < 4; n++) begin
            exp_src = n[0];
            #1;
            total++; if (a_ready !== ~exp_src || b_ready !== exp_src) begin bad++;
                $display("FAIL arb_grant%0d got=%b%b exp a=%b b=%b", n, a_ready, b_ready, ~exp_src, exp_src); end
            cyc(); cyc(); cyc(); #1;
            total++; if ({done, done_src, done_q, err} !== {1'b1, exp_src, exp_src, 1'b0}) begin bad++;
                $display("FAIL arb_done%0d got=%b exp=%b", n, {done, done_src, done_q, err},
                         {1'b1, exp_src, exp_src, 1'b0}); end
            #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        cyc();
    endtask

    task automatic test_hold();
        a_valid = 1'b1; a_idx = 4'd7; a_op = 2'b00;
        cyc(); a_valid = 1'b0; #1;
        total++; if (j_out !== 8'h00 || k_out !== 8'h00 || busy !== 1'b1) begin bad++;
            $display("FAIL hold_drive got j=%h k=%h busy=%b exp 00 00 1", j_out, k_out, busy); end
        cyc(); cyc(); #1;
        total++; if ({done, done_src, done_q, err} !== 4'b1010) begin bad++;
            $display("FAIL hold_done got=%b exp=1010", {done, done_src, done_q, err}); end
        cyc();
    endtask

    task automatic test_stuck();
        stuck5 = 1'b1;
        b_valid = 1'b1; b_idx = 4'd5; b_op = 2'b01;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL stuck_ready got=%b exp=1", b_ready); end
        cyc(); b_valid = 1'b0; #1;
        total++; if (j_out !== 8'h20 || k_out !== 8'h00) begin bad++;
            $display("FAIL stuck_drive got j=%h k=%h exp 20 00", j_out, k_out); end
        cyc(); cyc(); #1;
        total++; if ({done, done_src, done_q, err} !== 4'b1101) begin bad++;
            $display("FAIL stuck_done got=%b exp=1101", {done, done_src, done_q, err}); end
        stuck5 = 1'b0;
        cyc();
    endtask

    task automatic test_illegal_idx();
        a_valid = 1'b1; a_idx = 4'd9; a_op = 2'b01;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b exp=1", a_ready); end
        cyc(); a_valid = 1'b0; #1;
        total++; if (j_out !== 8'h00 || k_out !== 8'h00 || busy !== 1'b1) begin bad++;
            $display("FAIL ill_drive got j=%h k=%h busy=%b exp 00 00 1", j_out, k_out, busy); end
        cyc(); #1;
        total++; if (j_out !== 8'h00 || k_out !== 8'h00) begin bad++;
            $display("FAIL ill_sample got j=%h k=%h exp 00 00", j_out, k_out); end
        cyc(); #1;
        total++; if ({done, done_src, done_q, err} !== 4'b1001) begin bad++;
            $display("FAIL ill_done got=%b exp=1001", {done, done_src, done_q, err}); end
        cyc();
    endtask

    task automatic test_reset_abort();
        int seen_done;
        a_valid = 1'b1; a_idx = 4'd2; a_op = 2'b11;
        cyc(); a_valid = 1'b0; #1;
        total++; if (j_out !== 8'h04 || k_out !== 8'h04) begin bad++;
            $display("FAIL abort_drive got j=%h k=%h exp 04 04", j_out, k_out); end
        reset = 1'b1;
        cyc(); #1;
        total++; if ({j_out, k_out} !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL abort_cut got j=%h k=%h busy=%b done=%b exp 00 00 0 0", j_out, k_out, busy, done); end
        reset = 1'b0;
        seen_done = 0;
        for (int n = 0; n < 4; n++) begin
            cyc(); #1;
            if (done === 1'b1) seen_done++;
        end
        total++; if (seen_done != 0) begin bad++; $display("FAIL abort_no_done got=%0d pulses exp=0", seen_done); end
        a_valid = 1'b1; a_idx = 4'd1; a_op = 2'b01;
        b_valid = 1'b1; b_idx = 4'd6; b_op = 2'b01;
        #1;
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++;
            $display("FAIL abort_tie got=%b%b exp=10", a_ready, b_ready); end
        cyc(); a_valid = 1'b0; b_valid = 1'b0;
        cyc(); cyc(); #1;
        total++; if ({done, done_src, done_q, err} !== 4'b1010) begin bad++;
            $display("FAIL abort_after got=%b exp=1010", {done, done_src, done_q, err}); end
        cyc();
    endtask

    initial begin
        reset = 1'b1; bank_clr = 1'b1; stuck5 = 1'b0;
        a_valid = 1'b0; a_idx = '0; a_op = 2'b00;
        b_valid = 1'b0; b_idx = '0; b_op = 2'b00;
        test_reset();
        test_set();
        test_back_to_back();
        test_arbitration();
        test_hold();
        test_stuck();
        test_illegal_idx();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_jk_bank_ctrl
`default_nettype wire

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command sequencer and arbiter for a bank of N synchronous JK flip-flops. The bank itself is external; this block drives it through J/K vectors and reads back its Q vector.
- Two requesters (A, B) issue per-bit commands (hold/set/clear/toggle) over valid/ready. The block arbitrates round-robin and drives a one-cycle J/K pulse on the addressed bit.
- It samples the resulting Q, then returns a completion with the new bit value and a mismatch flag. This is the bench-visible control path for the flop bank.

Parameters:
- N_BITS, 8, number of JK flops in the bank.
- IDX_W, 3, bit-index width; must be at least clog2(N_BITS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  requester A command accepted this cycle.
- a_idx  in  IDX_W  requester A target bit.
- a_op  in  2  requester A operation.
- b_valid  in  1  requester B command valid.
- b_ready  out  1  requester B command accepted this cycle.
- b_idx  in  IDX_W  requester B target bit.
- b_op  in  2  requester B operation.
- j_out  out  N_BITS  J inputs to the bank.
- k_out  out  N_BITS  K inputs to the bank.
- q_in  in  N_BITS  Q outputs from the bank.
- busy  out  1  command in flight.
- done  out  1  one-cycle completion pulse.
- done_src  out  1  completing requester: 0 = A, 1 = B.
- done_q  out  1  bank bit value after the command.
- err  out  1  valid with done; read-back mismatch or illegal index.

Behaviour:
- Op encoding: J = op[0], K = op[1]. HOLD = 00, SET = 01, CLR = 10, TGL = 11.
- FSM states: IDLE -> DRIVE -> SAMPLE -> IDLE. Each state lasts exactly one cycle.
- IDLE arbitration:
  - grant_a = a_valid & (~b_valid | last_grant == B). grant_b = b_valid & ~grant_a.
  - a_ready = grant_a; b_ready = grant_b. Both ready outputs are combinational and high only in IDLE.
  - On a grant: latch idx, op and src; update last_grant; go to DRIVE.
  - No valid: stay in IDLE.
- Requester rule: valid and payload must stay stable until ready. The block never accepts two commands in one cycle.
- DRIVE:
  - j_out/k_out are registered and set on the acceptance edge. Only bit idx carries J/K per op; all other bits are 0.
  - Latch old = q_in[idx] during this cycle.
  - The bank captures at the end of DRIVE.
- SAMPLE:
  - j_out = k_out = 0.
  - At the end of the cycle: done_q <= q_in[idx]; done <= 1; err <= (q_in[idx] != expected).
  - expected = old for HOLD, 1 for SET, 0 for CLR, ~old for TGL.
- The next cycle is IDLE with done high for exactly that cycle. A new command can be accepted in that same cycle.
- Throughput: one command per 3 cycles. Latency from acceptance edge to done: 3 edges.
- busy = 1 in DRIVE and SAMPLE; 0 in IDLE.
- Illegal index (idx >= N_BITS):
  - Command is still accepted and the FSM runs normally.
  - j_out/k_out stay all-zero.
  - Completion gives done_q = 0, err = 1.
- HOLD: J/K = 00 pulse, i.e. no activity on the bank; completion reports the current value.
- Reset:
  - Any state -> IDLE at the next edge.
  - j_out = k_out = 0, done = done_src = done_q = err = 0, busy = 0, last_grant = B (so A wins the first tie).
  - An in-flight command is aborted: no done is produced, and the partial J/K pulse is removed at that edge.
  - a_ready/b_ready are 0 in any cycle where reset is high.
- done_src, done_q and err hold their values between done pulses; they are meaningful only when done = 1.

Decomposition:
- Shared package jk_pkg:
  - op encoding constants OP_HOLD, OP_SET, OP_CLR, OP_TGL;
  - FSM state encoding ST_IDLE, ST_DRIVE, ST_SAMPLE;
  - SRC_A / SRC_B constants.
- One sub-module: jk_rr_arb2, a 2-way round-robin arbiter.
  - Inputs: clk, reset, req[1:0], advance.
  - Output: grant[1:0].
  - Owns last_grant; reset value = B.

Test Plan:
- Reset then A SET idx 3 with bank all 0:
  - a_ready high at cycle 0;
  - j_out = 0x08, k_out = 0x00 for one cycle;
  - 3 edges after acceptance: done = 1, done_src = 0, done_q = 1, err = 0.
- A TGL idx 3 twice in a row after the SET:
  - first completion done_q = 0, second done_q = 1;
  - j_out = k_out = 0x08 in each DRIVE cycle;
  - the second command is accepted in the same cycle as the first done.
- A and B both valid every cycle (A CLR idx 0, B SET idx 7):
  - grants alternate A, B, A, B;
  - A completes first after reset; done_src alternates 0, 1, 0, 1.
- Bank model forced stuck-at-0 on bit 5, B SET idx 5: done = 1, done_q = 0, err = 1.
- A SET idx 9 with N_BITS = 8: j_out = k_out = 0 throughout; done = 1, done_q = 0, err = 1.
- A TGL accepted, then reset asserted during DRIVE:
  - j_out = k_out = 0 after that edge; no done pulse;
  - a simultaneous A/B request afterwards is granted to A.
